// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchronizer, debounce filter, press-edge
// detector, optional hold-to-repeat, and a sticky CPU-acknowledged event bit.
module btn_conditioner #(
  parameter int                N_BTN           = 4,
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter int                REPEAT_DELAY    = 25_000_000,
  parameter int                REPEAT_PERIOD   = 5_000_000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 4'b1110
) (
  input  logic             clk,
  input  logic             reset_rtl_0,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] event_o,
  input  logic [N_BTN-1:0] ack_i
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_DELAY = 2'd1,
    REPEATING  = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic             sync_p0;
    logic             sync_p1;
    logic             pressed;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic             accept;
    logic             press_edge;
    logic             held;
    rpt_state_t       state;
    rpt_state_t       state_nxt;
    logic [RC_W-1:0]  rpt_cnt;
    logic [RC_W-1:0]  rpt_cnt_nxt;
    logic             rpt_pulse;
    logic             press_q;
    logic             event_q;

    // Two-flop synchronizer; idles at 1 (released) out of reset.
    always_ff @(posedge clk) begin
      if (reset_rtl_0) begin
        sync_p0 <= 1'b1;
        sync_p1 <= 1'b1;
      end else begin
        sync_p0 <= btn_n[i];
        sync_p1 <= sync_p0;
      end
    end

    assign pressed    = ~sync_p1;
    // The filter accepts a change on the edge where the run of disagreeing
    // samples reaches its full length.
    assign accept     = (pressed != stable) && (db_cnt == DB_LAST);
    assign press_edge = accept & pressed;
    // Debounced level as it will be after this edge; lets a release that is
    // accepted this edge suppress a coincident repeat pulse.
    assign held       = accept ? pressed : stable;

    // Debounce: count consecutive samples disagreeing with the accepted level.
    always_ff @(posedge clk) begin
      if (reset_rtl_0) begin
        stable <= 1'b0;
        db_cnt <= '0;
      end else if (pressed == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= pressed;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    // Repeat FSM state and counter register.
    always_ff @(posedge clk) begin
      if (reset_rtl_0) begin
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        state   <= state_nxt;
        rpt_cnt <= rpt_cnt_nxt;
      end
    end

    // Repeat FSM next state: release (or disabled repeat) forces IDLE.
    always_comb begin
      state_nxt   = state;
      rpt_cnt_nxt = rpt_cnt;
      if (!REPEAT_MASK[i] || !held) begin
        state_nxt   = IDLE;
        rpt_cnt_nxt = '0;
      end else begin
        case (state)
          IDLE: begin
            if (press_edge) begin
              state_nxt   = HOLD_DELAY;
              rpt_cnt_nxt = '0;
            end
          end
          HOLD_DELAY: begin
            if (rpt_cnt == RD_LAST) begin
              state_nxt   = REPEATING;
              rpt_cnt_nxt = '0;
            end else begin
              rpt_cnt_nxt = rpt_cnt + RC_W'(1);
            end
          end
          REPEATING: begin
            if (rpt_cnt == RP_LAST) rpt_cnt_nxt = '0;
            else                    rpt_cnt_nxt = rpt_cnt + RC_W'(1);
          end
          default: begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
          end
        endcase
      end
    end

    // Repeat FSM output: pulse when the active interval expires while held.
    always_comb begin
      rpt_pulse = 1'b0;
      if (held) begin
        case (state)
          HOLD_DELAY: rpt_pulse = (rpt_cnt == RD_LAST);
          REPEATING:  rpt_pulse = (rpt_cnt == RP_LAST);
          default:    rpt_pulse = 1'b0;
        endcase
      end
    end

    // Registered press pulse and sticky event; a set beats a coincident ack.
    always_ff @(posedge clk) begin
      if (reset_rtl_0) begin
        press_q <= 1'b0;
        event_q <= 1'b0;
      end else begin
        press_q <= press_edge | rpt_pulse;
        event_q <= press_q | (event_q & ~ack_i[i]);
      end
    end

    assign level_o[i] = stable;
    assign press_o[i] = press_q;
    assign event_o[i] = event_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: directed stimulus, behavioural model
// compared every cycle, plus literal spot checks.
module tb_btn_conditioner;

  localparam int          N    = 4;
  localparam int          D    = 4;
  localparam int          RD   = 10;
  localparam int          RP   = 3;
  localparam logic [N-1:0] MASK = 4'b1110;

  logic         clk = 1'b0;
  logic         reset_rtl_0;
  logic [N-1:0] btn_n;
  logic [N-1:0] level_o;
  logic [N-1:0] press_o;
  logic [N-1:0] event_o;
  logic [N-1:0] ack_i;

  int n_pass  = 0;
  int n_total = 0;

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk        (clk),
    .reset_rtl_0(reset_rtl_0),
    .btn_n      (btn_n),
    .level_o    (level_o),
    .press_o    (press_o),
    .event_o    (event_o),
    .ack_i      (ack_i)
  );

  always #5 clk = ~clk;

  // Model state: synchronizer delay line, last D synchronized "pressed"
  // samples, accepted level, press pulse, event, cycles since accepted press.
  logic [N-1:0] m_s1, m_s2, m_stable, m_press, m_event;
  bit           m_hist [N][D];
  int           m_h    [N];
  bit           m_hv   [N];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: actual %b required %b", name, $time, act, exp);
  endtask

  task automatic model_step();
    if (reset_rtl_0) begin
      m_s1 = '1; m_s2 = '1;
      m_stable = '0; m_press = '0; m_event = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < D; j++) m_hist[i][j] = 1'b0;
        m_h[i] = 0; m_hv[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        bit all_diff, pedge, nstab, rpt;
        m_event[i] = m_press[i] | (m_event[i] & ~ack_i[i]);
        // Level flips once D consecutive samples all disagree with it.
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (m_hist[i][j] == m_stable[i]) all_diff = 1'b0;
        nstab = all_diff ? !m_stable[i] : m_stable[i];
        pedge = all_diff && !m_stable[i];
        if (pedge) begin m_h[i] = 0; m_hv[i] = 1'b1; end
        else if (m_hv[i]) m_h[i]++;
        if (!nstab) m_hv[i] = 1'b0;
        rpt = MASK[i] && m_hv[i] && !pedge &&
              (m_h[i] == RD || (m_h[i] > RD && (m_h[i] - RD) % RP == 0));
        m_press[i]  = pedge | rpt;
        m_stable[i] = nstab;
        for (int j = D - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = !m_s1[i];
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  endtask

  // Model advance on each edge, compare shortly after.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("level_model", level_o, m_stable);
      chk("press_model", press_o, m_press);
      chk("event_model", event_o, m_event);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_rtl_0 = 1'b1;
    btn_n       = 4'hF;
    ack_i       = 4'h0;

    // Reset values
    tick(1);
    chk("rst_level", level_o, 4'h0);
    chk("rst_press", press_o, 4'h0);
    chk("rst_event", event_o, 4'h0);
    tick(2);
    reset_rtl_0 = 1'b0;
    tick(2);
    chk("post_rst_level", level_o, 4'h0);
    chk("post_rst_event", event_o, 4'h0);

    // Clean press on button 0 (no repeat)
    btn_n[0] = 1'b0;
    tick(5);
    chk("clean_level_early", level_o, 4'h0);
    tick(1);
    chk("clean_level", level_o, 4'b0001);
    chk("clean_press", press_o, 4'b0001);
    chk("clean_event_lag", event_o, 4'h0);
    tick(1);
    chk("clean_press_1cyc", press_o, 4'h0);
    chk("clean_event", event_o, 4'b0001);
    tick(15);
    btn_n[0] = 1'b1;
    tick(8);
    chk("clean_release", level_o, 4'h0);
    chk("clean_event_sticky", event_o, 4'b0001);
    ack_i = 4'hF; tick(1); ack_i = 4'h0;
    chk("clean_ack", event_o, 4'h0);

    // Glitch on button 2 rejected, then accepted
    btn_n[2] = 1'b0; tick(3); btn_n[2] = 1'b1;
    tick(8);
    chk("glitch_level", level_o, 4'h0);
    chk("glitch_event", event_o, 4'h0);
    btn_n[2] = 1'b0; tick(4); btn_n[2] = 1'b1;
    tick(2);
    chk("glitch_accept_press", press_o, 4'b0100);
    chk("glitch_accept_level", level_o, 4'b0100);
    tick(8);
    ack_i = 4'hF; tick(1); ack_i = 4'h0;

    // Auto-repeat on button 1
    btn_n[1] = 1'b0;
    tick(6);
    chk("rpt_P", press_o, 4'b0010);
    tick(10);
    chk("rpt_P10", press_o, 4'b0010);
    tick(1);
    chk("rpt_P11", press_o, 4'h0);
    tick(2);
    chk("rpt_P13", press_o, 4'b0010);
    tick(3);
    chk("rpt_P16", press_o, 4'b0010);
    tick(14);
    btn_n[1] = 1'b1;
    tick(5);
    chk("rpt_rel_level_hold", level_o, 4'b0010);
    tick(1);
    chk("rpt_rel_level_fall", level_o, 4'h0);
    tick(10);
    ack_i = 4'hF; tick(1); ack_i = 4'h0;

    // Ack versus set on button 3
    btn_n[3] = 1'b0;
    tick(6);
    chk("ack_press", press_o, 4'b1000);
    ack_i = 4'b1000;
    tick(1);
    chk("ack_set_wins", event_o, 4'b1000);
    tick(1);
    chk("ack_lone_clear", event_o, 4'h0);
    ack_i = 4'h0;
    tick(9);
    chk("ack_repeat_sets", event_o, 4'b1000);
    ack_i = 4'b0001;
    tick(1);
    ack_i = 4'h0;
    chk("ack_other_bit", event_o, 4'b1000);
    btn_n[3] = 1'b1;
    tick(12);
    ack_i = 4'hF; tick(1); ack_i = 4'h0;

    // Reset mid-repeat with button 1 held
    btn_n[1] = 1'b0;
    tick(6);
    chk("mid_P", press_o, 4'b0010);
    tick(12);
    reset_rtl_0 = 1'b1;
    tick(1);
    chk("mid_rst_level", level_o, 4'h0);
    chk("mid_rst_press", press_o, 4'h0);
    chk("mid_rst_event", event_o, 4'h0);
    tick(1);
    reset_rtl_0 = 1'b0;
    tick(5);
    chk("mid_re_early", press_o, 4'h0);
    tick(1);
    chk("mid_re_press", press_o, 4'b0010);
    chk("mid_re_level", level_o, 4'b0010);
    tick(10);
    chk("mid_re_repeat", press_o, 4'b0010);
    btn_n = 4'hF;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
